// File: rtl/sram_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access; data has priority, with a streak bound on fetch starvation.
// Latency: 3 cycles minimum from the request being sampled in IDLE to done; the memory stalls the FSM by withholding mem_addr_ok or mem_data_ok.
module sram_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              mem_req,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_WAIT = 3'd2,
        D_ADDR = 3'd3,
        D_WAIT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_streak;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic              w_grant_d;
    logic              w_grant_i;

    // Data wins unless a waiting fetch has already been passed over MAX_DATA_STREAK times.
    assign w_grant_d = (r_state == IDLE) && data_req && (!inst_req || (r_streak < STREAK_MAX));
    assign w_grant_i = (r_state == IDLE) && !w_grant_d && inst_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = D_ADDR;
                end else if (w_grant_i) begin
                    w_next = I_ADDR;
                end
            end
            I_ADDR:  if (mem_addr_ok) w_next = I_WAIT;
            I_WAIT:  if (mem_data_ok) w_next = IDLE;
            D_ADDR:  if (mem_addr_ok) w_next = D_WAIT;
            D_WAIT:  if (mem_data_ok) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
            r_addr   <= '0;
            r_wen    <= '0;
            r_wdata  <= '0;
        end else if (w_grant_d) begin
            r_addr  <= data_addr;
            r_wen   <= data_wen;
            r_wdata <= data_wdata;
            if (!inst_req) begin
                r_streak <= '0;
            end else if (r_streak < STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;
            end
        end else if (w_grant_i) begin
            r_addr   <= inst_addr;
            r_wen    <= '0;
            r_wdata  <= '0;
            r_streak <= '0;
        end
    end

    // Responses outside the WAIT states (e.g. stale ones after reset) never reach a requester.
    assign inst_done  = (r_state == I_WAIT) && mem_data_ok;
    assign data_done  = (r_state == D_WAIT) && mem_data_ok;
    assign inst_rdata = inst_done ? mem_rdata : '0;
    assign data_rdata = data_done ? mem_rdata : '0;

    assign mem_req   = (r_state == I_ADDR) || (r_state == D_ADDR);
    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;

    assign stallreq = (inst_req && !inst_done) || (data_req && !data_done);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: fetch, collision, starvation bound, store backpressure, reset and spurious responses.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_rdata(inst_rdata),
        .inst_done(inst_done),
        .data_req(data_req),
        .data_wen(data_wen),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .data_done(data_done),
        .mem_req(mem_req),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata),
        .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst         = 1'b1;
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wen    = '0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_inst_done", 64'(inst_done), 64'd0);
        chk("rst_data_done", 64'(data_done), 64'd0);
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        chk("rst_streak", 64'(dut.r_streak), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single fetch
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00000;
        settle();
        chk("f_idle_mem_req", 64'(mem_req), 64'd0);
        chk("f_idle_stall", 64'(stallreq), 64'd1);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("f_mem_req", 64'(mem_req), 64'd1);
        chk("f_mem_addr", 64'(mem_addr), 64'hBFC00000);
        chk("f_mem_wen", 64'(mem_wen), 64'd0);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h24010001;
        settle();
        chk("f_inst_done", 64'(inst_done), 64'd1);
        chk("f_inst_rdata", 64'(inst_rdata), 64'h24010001);
        chk("f_stall_done", 64'(stallreq), 64'd0);
        chk("f_wait_mem_req", 64'(mem_req), 64'd0);
        tick();
        inst_req    = 1'b0;
        mem_data_ok = 1'b0;
        settle();
        chk("f_after_done", 64'(inst_done), 64'd0);
        chk("f_after_mem_req", 64'(mem_req), 64'd0);

        // Collision: data first, fetch after
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h00000100;
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h80000010;
        settle();
        chk("c_idle_stall", 64'(stallreq), 64'd1);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("c_d_mem_addr", 64'(mem_addr), 64'h80000010);
        chk("c_d_mem_req", 64'(mem_req), 64'd1);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h11112222;
        settle();
        chk("c_data_done", 64'(data_done), 64'd1);
        chk("c_data_rdata", 64'(data_rdata), 64'h11112222);
        chk("c_no_inst_done", 64'(inst_done), 64'd0);
        chk("c_stall_held", 64'(stallreq), 64'd1);
        tick();
        data_req    = 1'b0;
        mem_data_ok = 1'b0;
        settle();
        chk("c_idle2_stall", 64'(stallreq), 64'd1);
        chk("c_idle2_mem_req", 64'(mem_req), 64'd0);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("c_i_mem_addr", 64'(mem_addr), 64'h00000100);
        chk("c_i_mem_req", 64'(mem_req), 64'd1);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h33334444;
        settle();
        chk("c_inst_done", 64'(inst_done), 64'd1);
        chk("c_inst_rdata", 64'(inst_rdata), 64'h33334444);
        chk("c_stall_clear", 64'(stallreq), 64'd0);
        tick();
        inst_req    = 1'b0;
        mem_data_ok = 1'b0;

        // Starvation bound: four data grants then the fetch
        inst_req  = 1'b1;
        inst_addr = 32'h00000200;
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            data_addr = 32'h80000100 + 32'(i * 4);
            settle();
            chk("s_idle_mem_req", 64'(mem_req), 64'd0);
            tick();
            mem_addr_ok = 1'b1;
            settle();
            chk("s_d_mem_addr", 64'(mem_addr), 64'h80000100 + 64'(i * 4));
            chk("s_streak", 64'(dut.r_streak), 64'(i + 1));
            tick();
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hA0000000 + 32'(i);
            settle();
            chk("s_data_done", 64'(data_done), 64'd1);
            chk("s_no_inst_done", 64'(inst_done), 64'd0);
            tick();
            mem_data_ok = 1'b0;
        end
        data_addr = 32'h80000200;
        settle();
        chk("s_idle5_mem_req", 64'(mem_req), 64'd0);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("s_i_mem_addr", 64'(mem_addr), 64'h00000200);
        chk("s_i_mem_wen", 64'(mem_wen), 64'd0);
        chk("s_streak_clr", 64'(dut.r_streak), 64'd0);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0BADF00D;
        settle();
        chk("s_inst_done", 64'(inst_done), 64'd1);
        chk("s_inst_rdata", 64'(inst_rdata), 64'h0BADF00D);
        chk("s_stall_data_wait", 64'(stallreq), 64'd1);
        tick();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_data_ok = 1'b0;

        // Store with addr_ok withheld for three cycles
        tick();
        data_req   = 1'b1;
        data_wen   = 4'b0011;
        data_addr  = 32'h80000020;
        data_wdata = 32'hDEADBEEF;
        settle();
        chk("w_idle_mem_req", 64'(mem_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_addr_ok = (i == 3);
            settle();
            chk("w_mem_req", 64'(mem_req), 64'd1);
            chk("w_mem_addr", 64'(mem_addr), 64'h80000020);
            chk("w_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
            chk("w_mem_wen", 64'(mem_wen), 64'h3);
            chk("w_no_done", 64'(data_done), 64'd0);
        end
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("w_data_done", 64'(data_done), 64'd1);
        chk("w_stall_clear", 64'(stallreq), 64'd0);
        tick();
        data_req    = 1'b0;
        data_wen    = 4'b0000;
        mem_data_ok = 1'b0;

        // Reset pulsed in D_WAIT; stale response afterwards is dropped
        tick();
        data_req  = 1'b1;
        data_addr = 32'h80000040;
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("r_d_mem_req", 64'(mem_req), 64'd1);
        tick();
        mem_addr_ok = 1'b0;
        rst         = 1'b1;
        data_req    = 1'b0;
        settle();
        chk("r_in_rst_mem_req", 64'(mem_req), 64'd0);
        chk("r_in_rst_done", 64'(data_done), 64'd0);
        tick();
        rst         = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFF0000;
        settle();
        chk("r_stale_data_done", 64'(data_done), 64'd0);
        chk("r_stale_inst_done", 64'(inst_done), 64'd0);
        chk("r_stale_mem_req", 64'(mem_req), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h00000300;
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("r_i_mem_req", 64'(mem_req), 64'd1);
        chk("r_i_mem_addr", 64'(mem_addr), 64'h00000300);
        chk("r_i_mem_wen", 64'(mem_wen), 64'd0);
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h12345678;
        settle();
        chk("r_inst_done", 64'(inst_done), 64'd1);
        chk("r_inst_rdata", 64'(inst_rdata), 64'h12345678);
        tick();
        inst_req    = 1'b0;
        mem_data_ok = 1'b0;

        // Spurious response while idle
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h55555555;
        settle();
        chk("p_inst_done", 64'(inst_done), 64'd0);
        chk("p_data_done", 64'(data_done), 64'd0);
        chk("p_stall", 64'(stallreq), 64'd0);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("p_mem_req", 64'(mem_req), 64'd0);
        chk("p_state_idle", 64'(dut.r_state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the core's instruction-fetch and data-access requests onto one shared single-port memory interface with address/data handshakes.
- Sits between IF/EX+MEM and the memory bridge.
- Returns read data and a one-cycle completion strobe to each requester.
- Raises a stall request to CTRL while any requester is waiting.
- Data side has priority; a streak counter bounds instruction-fetch starvation.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DATA_STREAK, 4, consecutive data grants allowed while an inst request waits (must be ≥1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
inst_req  input  1  IF requests a fetch; held stable until inst_done
inst_addr  input  ADDR_W  fetch address
inst_rdata  output  DATA_W  fetch data, valid only when inst_done=1
inst_done  output  1  fetch complete, single-cycle strobe
data_req  input  1  MEM-stage access request; held stable until data_done
data_wen  input  4  byte write enables; 0 means read
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_rdata  output  DATA_W  load data, valid only when data_done=1
data_done  output  1  data access complete, single-cycle strobe
mem_req  output  1  request valid on shared port
mem_wen  output  4  byte enables of the granted request
mem_addr  output  ADDR_W  address of the granted request
mem_wdata  output  DATA_W  write data of the granted request
mem_addr_ok  input  1  memory accepts request this cycle
mem_data_ok  input  1  response/write-ack this cycle
mem_rdata  input  DATA_W  response data
stallreq  output  1  stall request to CTRL

Behaviour:
- Clocking/reset: clk is the only clock. rst is asynchronous and active-high.
- Reset state: state=IDLE, streak=0, latched request regs=0. Outputs are mem_req=0, inst_done=0, data_done=0. stallreq follows its combinational equation.
- FSM states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
- IDLE arbitration:
  - data_req & (~inst_req | streak<MAX_DATA_STREAK) → D_ADDR.
  - Otherwise inst_req → I_ADDR.
  - Otherwise stay in IDLE.
- Grant latch:
  - On a grant, the requester's addr, wen and wdata are registered.
  - Inst grants register wen=0 and wdata=0.
  - mem_* outputs drive only from these latched registers.
- Streak counter:
  - On a data grant with inst_req=1, streak increments, saturating at MAX_DATA_STREAK.
  - On a data grant with inst_req=0, streak clears.
  - On an inst grant, streak clears.
- ADDR states:
  - mem_req=1.
  - On mem_addr_ok go to the matching WAIT state; otherwise hold, keeping outputs stable.
  - mem_req=0 in every other state.
- WAIT states:
  - On mem_data_ok, return to IDLE.
  - In that same cycle, assert the matching done combinationally and drive rdata=mem_rdata.
  - mem_data_ok in IDLE or in ADDR states is ignored; this covers stale responses after a mid-transaction reset.
- Latency: minimum 3 cycles, from req sampled in IDLE (cycle N) to done (cycle N+2), when addr_ok and data_ok arrive at the earliest point. One transaction is outstanding at a time; no pipelining.
- Post-done: the requester advances on the edge ending the done cycle. A new request is arbitrated in IDLE the following cycle.
- Writes: a store completes with data_done on mem_data_ok. data_rdata is don't-care for stores.
- stallreq = (inst_req & ~inst_done) | (data_req & ~data_done). It is combinational and deasserts in the done cycle.
- Simultaneous requests in IDLE: data wins unless the streak is saturated. Requests arriving while busy wait in IDLE for arbitration.
- Reset mid-transaction: the FSM returns to IDLE immediately and mem_req drops asynchronously. Any in-flight memory response is dropped.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; addr_ok in cycle 1, data_ok with mem_rdata=0x24010001 in cycle 2 → mem_addr=0xBFC00000, mem_wen=0, inst_done=1 and inst_rdata=0x24010001 in cycle 2, stallreq=0 in cycle 2.
- Collision: inst_req and data_req (read 0x80000010) both high in IDLE → data granted first, inst granted after data_done. stallreq stays 1 until inst_done.
- Starvation bound: inst_req held, data_req back-to-back with MAX_DATA_STREAK=4 → exactly 4 data transactions, then an inst grant, then streak=0.
- Store with backpressure: data_wen=4'b0011, addr 0x80000020, wdata 0xDEADBEEF; addr_ok withheld 3 cycles → mem_req/addr/wdata/wen stable for all 4 cycles, data_done on data_ok.
- Mid-operation reset: rst pulsed in D_WAIT, then mem_data_ok=1 the cycle after release → no done strobe, mem_req=0, and the next inst_req is served normally.
- Spurious response: mem_data_ok=1 while IDLE with no requests → inst_done=data_done=0 and state unchanged.
